rtc_trigger: RTL

RTC_TRIGGER -- requirements
Module: rtc_trigger

---
 rtl/rtc_trigger.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/rtc_trigger.sv
// rtc_trigger: button front end and run/pause/clear FSM for the stopwatch.
//
// Each raw active-low button goes through a 2-flop synchronizer. It is then
// debounced on the i_basetick strobe and reduced to a one-cycle press event
// on the released->pressed edge of the debounced level. The press events
// drive a three-state IDLE/RUN/PAUSE controller.
//
// Parameters:
//   DEBOUNCE_TICKS  consecutive basetick samples needed to accept a new level (1..15)
// Ports:
//   i_clk           system clock, rising edge
//   i_reset_n       asynchronous active-low reset
//   i_basetick      one-cycle 10 ms strobe; debounce sample point
//   i_startstop_n   raw start/stop button, active low
//   i_clear_n       raw clear button, active low
//   i_lap_n         raw lap button, active low (RTC_TRIGGER_LAP_EN only)
//   o_countenb      count enable, high in RUN
//   o_latchcount    count-advance qualifier, high in RUN
//   o_countinit     one-cycle counter clear pulse
//   o_state         00 IDLE, 01 RUN, 10 PAUSE
//   o_displayhold   display freeze flag (RTC_TRIGGER_LAP_EN only)
//
// Build option: define RTC_TRIGGER_LAP_EN to add the lap button and o_displayhold.
module rtc_trigger #(
  parameter logic [3:0] DEBOUNCE_TICKS = 4'd2
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_basetick,
  input  logic       i_startstop_n,
  input  logic       i_clear_n,
`ifdef RTC_TRIGGER_LAP_EN
  input  logic       i_lap_n,
  output logic       o_displayhold,
`endif
  output logic       o_countenb,
  output logic       o_latchcount,
  output logic       o_countinit,
  output logic [1:0] o_state
);

`ifdef RTC_TRIGGER_LAP_EN
  localparam int unsigned NBTN = 3;
`else
  localparam int unsigned NBTN = 2;
`endif

  localparam int unsigned BTN_SS  = 0;
  localparam int unsigned BTN_CLR = 1;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;

  logic [NBTN-1:0]      raw;
  logic [NBTN-1:0]      sync1_q;
  logic [NBTN-1:0]      sync2_q;
  logic [NBTN-1:0]      db_q;
  logic [NBTN-1:0]      db_d;
  logic [NBTN-1:0]      db_dly_q;
  logic [NBTN-1:0]      press;
  logic [NBTN-1:0][3:0] cnt_q;
  logic [NBTN-1:0][3:0] cnt_d;

  logic [1:0] state_q, state_d;
  logic       init_q, init_d;
  logic       enb_q, latch_q, run_d;

  assign raw[BTN_SS]  = i_startstop_n;
  assign raw[BTN_CLR] = i_clear_n;
`ifdef RTC_TRIGGER_LAP_EN
  assign raw[2]       = i_lap_n;
`endif

  // Debounce: a sample equal to the accepted level restarts the count, so
  // only an unbroken run of DEBOUNCE_TICKS differing samples flips the level.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int unsigned b = 0; b < NBTN; b++) begin
      if (i_basetick) begin
        if (sync2_q[b] == db_q[b]) begin
          cnt_d[b] = '0;
        end else if ((cnt_q[b] + 4'd1) >= DEBOUNCE_TICKS) begin
          db_d[b]  = sync2_q[b];
          cnt_d[b] = '0;
        end else begin
          cnt_d[b] = cnt_q[b] + 4'd1;
        end
      end
    end
  end

  // Press event on released(1) -> pressed(0); releases are ignored.
  assign press = db_dly_q & ~db_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      db_q     <= '1;
      db_dly_q <= '1;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      cnt_q    <= cnt_d;
    end
  end

  // Start/stop wins over clear in the same cycle; clear is dropped in RUN.
  always_comb begin
    state_d = state_q;
    init_d  = 1'b0;
    if (press[BTN_SS]) begin
      if (state_q == ST_RUN) state_d = ST_PAUSE;
      else                   state_d = ST_RUN;
    end else if (press[BTN_CLR] && (state_q != ST_RUN)) begin
      state_d = ST_IDLE;
      init_d  = 1'b1;
    end
  end

  // Enables are registered from the next state so they line up with o_state.
  assign run_d = (state_d == ST_RUN);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      init_q  <= 1'b0;
      enb_q   <= 1'b0;
      latch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      enb_q   <= run_d;
      latch_q <= run_d;
    end
  end

`ifdef RTC_TRIGGER_LAP_EN
  logic hold_q, hold_d;

  always_comb begin
    hold_d = hold_q;
    if (state_d == ST_IDLE) begin
      hold_d = 1'b0;
    end else if (press[2] && (state_q == ST_RUN)) begin
      hold_d = ~hold_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) hold_q <= 1'b0;
    else            hold_q <= hold_d;
  end

  assign o_displayhold = hold_q;
`endif

  assign o_state      = state_q;
  assign o_countenb   = enb_q;
  assign o_latchcount = latch_q;
  assign o_countinit  = init_q;

endmodule
